// File: rtl/stage2_pool_core.sv
// rtl/stage2_pool_core.sv - streaming 2x2 stride-2 signed max-pooling stage
// Pools a raster-ordered multi-channel feature map; one output pulse per 2x2 window.
module stage2_pool_core #(
  parameter int CI  = 3,
  parameter int IBW = 20,
  parameter int IX  = 24,
  parameter int IY  = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_in_valid,
  input  logic [CI*IBW-1:0] i_in_fmap,
  output logic              o_ot_valid,
  output logic [CI*IBW-1:0] o_ot_fmap
);

  localparam int XW = $clog2(IX);
  localparam int YW = $clog2(IY);

  logic [XW-1:0]     x_cnt;
  logic [YW-1:0]     y_cnt;
  logic [XW-2:0]     lb_idx;
  logic              x_last;
  logic              y_last;
  logic [CI*IBW-1:0] hold_q;
  logic [CI*IBW-1:0] line_buf [IX/2];
  logic [CI*IBW-1:0] h_vec;
  logic [CI*IBW-1:0] o_vec;

  function automatic logic [IBW-1:0] smax(input logic [IBW-1:0] a, input logic [IBW-1:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

  assign lb_idx = x_cnt[XW-1:1];
  assign x_last = (x_cnt == XW'(IX - 1));
  assign y_last = (y_cnt == YW'(IY - 1));

  // h: horizontal pair max; o: h against the pair stored from the row above
  always_comb begin
    h_vec = '0;
    o_vec = '0;
    for (int c = 0; c < CI; c++) begin
      h_vec[c*IBW +: IBW] = smax(hold_q[c*IBW +: IBW], i_in_fmap[c*IBW +: IBW]);
      o_vec[c*IBW +: IBW] = smax(h_vec[c*IBW +: IBW], line_buf[lb_idx][c*IBW +: IBW]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_cnt      <= '0;
      y_cnt      <= '0;
      o_ot_valid <= 1'b0;
      o_ot_fmap  <= '0;
    end else begin
      o_ot_valid <= 1'b0;
      if (i_in_valid) begin
        if (x_last) begin
          x_cnt <= '0;
          y_cnt <= y_last ? '0 : y_cnt + YW'(1);
        end else begin
          x_cnt <= x_cnt + XW'(1);
        end
        if (x_cnt[0] && y_cnt[0]) begin
          o_ot_valid <= 1'b1;
          o_ot_fmap  <= o_vec;
        end
      end
    end
  end

  // Datapath storage needs no reset: every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (i_in_valid) begin
      if (!x_cnt[0])
        hold_q <= i_in_fmap;
      else if (!y_cnt[0])
        line_buf[lb_idx] <= h_vec;
    end
  end

endmodule

// File: tb/tb_stage2_pool_core.sv
// tb/tb_stage2_pool_core.sv - self-checking bench for stage2_pool_core
// Frame-array pooling model, per-cycle output compare, literal pins on known patterns.
module tb_stage2_pool_core;

  localparam int CI  = 3;
  localparam int IBW = 20;
  localparam int IX  = 24;
  localparam int IY  = 24;
  localparam int W   = CI * IBW;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         i_in_valid = 1'b0;
  logic [W-1:0] i_in_fmap = '0;
  logic         o_ot_valid;
  logic [W-1:0] o_ot_fmap;

  logic         in_qual = 1'b0;
  logic         pend;
  int           checks = 0;
  int           errors = 0;
  int           pix [IY][IX][CI];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] got_q [$];
  logic [W-1:0] ref_q [$];

  always #5 clk = ~clk;

  stage2_pool_core #(.CI(CI), .IBW(IBW), .IX(IX), .IY(IY)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_in_valid (i_in_valid),
    .i_in_fmap  (i_in_fmap),
    .o_ot_valid (o_ot_valid),
    .o_ot_fmap  (o_ot_fmap)
  );

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  function automatic int lane(input logic [W-1:0] v, input int c);
    logic signed [IBW-1:0] t;
    t = v[c*IBW +: IBW];
    return int'(t);
  endfunction

  function automatic int got_lane(input int i, input int c);
    if (i >= got_q.size()) return -999999;
    return lane(got_q[i], c);
  endfunction

  // mode 0 ramp, 1 negative, 2 hot pixel, 3 random full-range
  task automatic fill(input int mode, input int offset);
    for (int y = 0; y < IY; y++)
      for (int x = 0; x < IX; x++)
        for (int c = 0; c < CI; c++)
          case (mode)
            0: pix[y][x][c] = 24*y + x + 1000*c + offset;
            1: pix[y][x][c] = (c == 0) ? -(24*y + x) : -5;
            2: pix[y][x][c] = (y == 3 && x == 5 && c == 1) ? 77 : 0;
            default: pix[y][x][c] = int'($urandom_range(0, (1 << IBW) - 1)) - (1 << (IBW - 1));
          endcase
  endtask

  function automatic logic [W-1:0] pack(input int y, input int x);
    logic [W-1:0] v;
    for (int c = 0; c < CI; c++) v[c*IBW +: IBW] = IBW'(pix[y][x][c]);
    return v;
  endfunction

  function automatic logic [W-1:0] pooled(input int py, input int px);
    logic [W-1:0] v;
    int m;
    for (int c = 0; c < CI; c++) begin
      m = pix[2*py][2*px][c];
      for (int dy = 0; dy < 2; dy++)
        for (int dx = 0; dx < 2; dx++)
          if (pix[2*py+dy][2*px+dx][c] > m) m = pix[2*py+dy][2*px+dx][c];
      v[c*IBW +: IBW] = IBW'(m);
    end
    return v;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_frame(input int gap_pct, input int stop_y, input int stop_x);
    for (int y = 0; y < IY; y++)
      for (int x = 0; x < IX; x++) begin
        if (y == stop_y && x == stop_x) begin
          i_in_valid = 1'b0;
          in_qual = 1'b0;
          return;
        end
        while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
          i_in_valid = 1'b0;
          in_qual = 1'b0;
          @(posedge clk);
          #1;
        end
        i_in_valid = 1'b1;
        i_in_fmap = pack(y, x);
        in_qual = (y % 2 == 1) && (x % 2 == 1);
        if (in_qual) exp_q.push_back(pooled(y / 2, x / 2));
        @(posedge clk);
        #1;
      end
    i_in_valid = 1'b0;
    in_qual = 1'b0;
  endtask

  always @(posedge clk or negedge reset_n)
    if (!reset_n) pend <= 1'b0;
    else          pend <= i_in_valid && in_qual;

  always @(negedge clk) begin
    if (!reset_n) begin
      check("reset_valid", longint'(o_ot_valid), 0);
      check("reset_fmap_zero", longint'(o_ot_fmap == '0), 1);
    end else begin
      check("valid_timing", longint'(o_ot_valid), longint'(pend));
      if (o_ot_valid) begin
        got_q.push_back(o_ot_fmap);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: actual lane0 %0d required no pulse", lane(o_ot_fmap, 0));
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          for (int c = 0; c < CI; c++) check("out_lane", lane(o_ot_fmap, c), lane(e, c));
        end
      end
    end
  end

  initial begin
    int nz;
    #1 reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;
    idle(1);

    fill(0, 0); got_q.delete();
    drive_frame(0, -1, -1); idle(3);
    check("ramp_count", got_q.size(), 144);
    check("ramp_first_l0", got_lane(0, 0), 25);
    check("ramp_first_l1", got_lane(0, 1), 1025);
    check("ramp_first_l2", got_lane(0, 2), 2025);
    check("ramp_second_l0", got_lane(1, 0), 27);
    check("ramp_second_l1", got_lane(1, 1), 1027);
    check("ramp_second_l2", got_lane(1, 2), 2027);
    check("ramp_last_l0", got_lane(143, 0), 575);
    check("ramp_drain", exp_q.size(), 0);
    ref_q = got_q;

    fill(1, 0); got_q.delete();
    drive_frame(0, -1, -1); idle(3);
    check("neg_count", got_q.size(), 144);
    check("neg_first_l0", got_lane(0, 0), 0);
    check("neg_second_l0", got_lane(1, 0), -2);
    check("neg_third_l0", got_lane(2, 0), -4);
    check("neg_l1", got_lane(5, 1), -5);
    check("neg_l2", got_lane(143, 2), -5);

    fill(0, 0); got_q.delete();
    drive_frame(50, -1, -1); idle(3);
    check("gap_count", got_q.size(), ref_q.size());
    for (int i = 0; i < ref_q.size(); i++) begin
      check("gap_seq_l0", got_lane(i, 0), lane(ref_q[i], 0));
      check("gap_seq_l2", got_lane(i, 2), lane(ref_q[i], 2));
    end

    fill(0, 0); got_q.delete();
    drive_frame(0, -1, -1);
    fill(0, 5000);
    drive_frame(0, -1, -1); idle(3);
    check("b2b_count", got_q.size(), 288);
    check("b2b_145_l0", got_lane(144, 0), 5025);
    check("b2b_last_l0", got_lane(287, 0), 5575);

    fill(0, 0); got_q.delete();
    drive_frame(0, 7, 10); idle(2);
    reset_n = 1'b0;
    idle(3);
    check("no_stale_pending", exp_q.size(), 0);
    exp_q.delete(); got_q.delete();
    reset_n = 1'b1;
    idle(1);
    check("post_reset_quiet", got_q.size(), 0);
    drive_frame(0, -1, -1); idle(3);
    check("rst_count", got_q.size(), 144);
    check("rst_first_l0", got_lane(0, 0), 25);

    fill(2, 0); got_q.delete();
    drive_frame(0, -1, -1); idle(3);
    check("hot_count", got_q.size(), 144);
    check("hot_idx14_l1", got_lane(14, 1), 77);
    nz = 0;
    for (int i = 0; i < got_q.size(); i++)
      for (int c = 0; c < CI; c++)
        if (!(i == 14 && c == 1) && got_lane(i, c) != 0) nz++;
    check("hot_others_zero", nz, 0);

    for (int f = 0; f < 2; f++) begin
      fill(3, 0); got_q.delete();
      drive_frame(30, -1, -1); idle(3);
      check("rand_count", got_q.size(), 144);
      check("rand_drain", exp_q.size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
